// File: rtl/mdu_if.sv
// EXE <-> MDU request/response bundle: instruction handshake, flush, read-back and HI/LO.
// Latency: none (wires only).
// Backpressure: the requester holds in_valid/op/src_* until in_ready is seen.
interface mdu_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              flush;
    logic              busy;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    // pipeline (EXE) side
    modport master (
        output in_valid, op, src_a, src_b, flush,
        input  in_ready, busy, rd_valid, rd_data, hi_o, lo_o
    );

    // multiply/divide unit side
    modport slave (
        input  in_valid, op, src_a, src_b, flush,
        output in_ready, busy, rd_valid, rd_data, hi_o, lo_o
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle mult/div sequencer and owner of the architectural HI/LO pair.
// Latency: mfhi/mflo same cycle; mt* next edge; mult/div commit DATA_W+1 edges after accept.
// Backpressure: in_ready is low while a mult/div runs, during flush and during reset.
module mdu_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic  clk,
    input  logic  rst_n,
    mdu_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        FIXUP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    // mult: multiplicand magnitude; div: divisor magnitude
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    // mult: {partial product, remaining multiplier}; div: {remainder, quotient}
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic                is_div_q, is_div_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    logic [7:0]          op_sel;
    logic                xfer;
    logic                signed_op;
    logic                a_neg, b_neg;
    logic [DATA_W-1:0]   abs_a, abs_b;
    logic                start_mul, start_div;
    logic                last_step;

    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;
    logic                div_ge;
    logic [DATA_W-1:0]   div_rem;
    logic [2*DATA_W-1:0] div_next;

    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    // lowest set op bit wins, so the decode is always one-hot or zero
    assign op_sel    = bus.op & (~bus.op + 8'd1);

    assign bus.in_ready = rst_n & (state_q == IDLE) & ~bus.flush;
    assign xfer         = bus.in_valid & bus.in_ready;
    assign bus.busy     = (state_q != IDLE);

    assign bus.rd_valid = xfer & (op_sel[4] | op_sel[5]);
    assign bus.rd_data  = (xfer & op_sel[4]) ? hi_q :
                          (xfer & op_sel[5]) ? lo_q : '0;
    assign bus.hi_o     = hi_q;
    assign bus.lo_o     = lo_q;

    // only mult and div look at operand signs
    assign signed_op = op_sel[0] | op_sel[2];
    assign a_neg     = signed_op & bus.src_a[DATA_W-1];
    assign b_neg     = signed_op & bus.src_b[DATA_W-1];
    assign abs_a     = a_neg ? -bus.src_a : bus.src_a;
    assign abs_b     = b_neg ? -bus.src_b : bus.src_b;
    assign start_mul = op_sel[0] | op_sel[1];
    assign start_div = op_sel[2] | op_sel[3];
    assign last_step = (cnt_q == CNT_W'(DATA_W - 1));

    // shift-add: add multiplicand into the upper half when the current multiplier bit is set, then shift right
    assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

    // restoring step: bring in the next dividend bit, keep the difference only if it did not go negative
    assign div_shift = acc_q[2*DATA_W-1:DATA_W-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_rem   = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
    assign div_next  = {div_rem, acc_q[DATA_W-2:0], div_ge};

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

    // next-state, datapath step and HI/LO writes
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (op_sel[6]) hi_d = bus.src_a;
                    if (op_sel[7]) lo_d = bus.src_a;
                    if (start_mul || start_div) begin
                        cnt_d     = '0;
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        is_div_d  = start_div;
                    end
                    if (start_mul) begin
                        opnd_d  = abs_a;
                        acc_d   = {{DATA_W{1'b0}}, abs_b};
                        state_d = MUL_RUN;
                    end
                    if (start_div) begin
                        opnd_d  = abs_b;
                        acc_d   = {{DATA_W{1'b0}}, abs_a};
                        state_d = DIV_RUN;
                    end
                end
            end
            MUL_RUN, DIV_RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = (state_q == DIV_RUN) ? div_next : mul_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_step) state_d = FIXUP;
                end
            end
            FIXUP: begin
                state_d = IDLE;
                if (!bus.flush) begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*DATA_W-1:DATA_W];
                        lo_d = prod_fix[DATA_W-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // register update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule
